// File: rtl/mem_stage_pkg.sv
// Shared widths, write-back/register-class encodings, SRAM FSM states and
// the write-back source mux used by the memory stage.
package mem_stage_pkg;

   localparam int DATA_BUS       = 16;
   localparam int REG_ADDR_BUS   = 4;
   localparam int WB_DATA_OP_BUS = 2;
   localparam int REG_OP_BUS     = 2;

   localparam logic [WB_DATA_OP_BUS-1:0] WB_ALU = 2'd0;
   localparam logic [WB_DATA_OP_BUS-1:0] WB_RAM = 2'd1;
   localparam logic [WB_DATA_OP_BUS-1:0] WB_PC  = 2'd2;
   localparam logic [WB_DATA_OP_BUS-1:0] WB_IH  = 2'd3;

   localparam logic [REG_OP_BUS-1:0] REG_OP_NONE = 2'd0;

   localparam logic RAM_READ  = 1'b0;
   localparam logic RAM_WRITE = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_SETUP = 3'd1,
      ST_RD_LATCH = 3'd2,
      ST_WR_SETUP = 3'd3,
      ST_WR_PULSE = 3'd4,
      ST_WR_HOLD  = 3'd5
   } sram_state_t;

   // RAM source yields 0 here; the real read data is substituted on retire.
   function automatic logic [DATA_BUS-1:0] wb_mux(
      input logic [WB_DATA_OP_BUS-1:0] sel,
      input logic [DATA_BUS-1:0]       alu,
      input logic [DATA_BUS-1:0]       pc,
      input logic [DATA_BUS-1:0]       ih
   );
      case (sel)
         WB_ALU:  return alu;
         WB_PC:   return pc;
         WB_IH:   return ih;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl.sv
// Asynchronous SRAM access sequencer: latches the request, walks the
// setup/strobe/hold phases and drives registered, glitch-free strobes.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   IDLE      | no access; strobes inactive, address/data 0
//   RD_SETUP  | ce_n/oe_n low, address settling
//   RD_LATCH  | ce_n/oe_n low, read data sampled at end of cycle
//   WR_SETUP  | ce_n low, data driven, we_n still high
//   WR_PULSE  | we_n low for exactly this cycle
//   WR_HOLD   | we_n high again, address/data held one more cycle
module sram_ctrl
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = 18
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   input  logic                i_op,
   input  logic [DATA_BUS-1:0] i_addr,
   input  logic [DATA_BUS-1:0] i_wdata,
   output logic                o_busy,
   output logic                o_done,
   output logic [ADDR_W-1:0]   o_ram_addr,
   output logic [DATA_BUS-1:0] o_ram_wdata,
   output logic                o_ram_data_oe,
   output logic                o_ram_ce_n,
   output logic                o_ram_oe_n,
   output logic                o_ram_we_n
);

   sram_state_t         r_state;
   logic [DATA_BUS-1:0] r_addr_q;
   logic [DATA_BUS-1:0] r_wdata_q;
   logic [ADDR_W-1:0]   w_addr_in_ext;
   logic [ADDR_W-1:0]   w_addr_q_ext;

   assign w_addr_in_ext = {{(ADDR_W-DATA_BUS){1'b0}}, i_addr};
   assign w_addr_q_ext  = {{(ADDR_W-DATA_BUS){1'b0}}, r_addr_q};

   // Sequencer; every output is loaded with the value for the state being entered.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= ST_IDLE;
         r_addr_q      <= '0;
         r_wdata_q     <= '0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_ram_addr    <= '0;
         o_ram_wdata   <= '0;
         o_ram_data_oe <= 1'b0;
         o_ram_ce_n    <= 1'b1;
         o_ram_oe_n    <= 1'b1;
         o_ram_we_n    <= 1'b1;
      end else begin
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_ram_addr    <= '0;
         o_ram_wdata   <= '0;
         o_ram_data_oe <= 1'b0;
         o_ram_ce_n    <= 1'b1;
         o_ram_oe_n    <= 1'b1;
         o_ram_we_n    <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_addr_q   <= i_addr;
                  r_wdata_q  <= i_wdata;
                  o_busy     <= 1'b1;
                  o_ram_ce_n <= 1'b0;
                  o_ram_addr <= w_addr_in_ext;
                  if (i_op == RAM_WRITE) begin
                     r_state       <= ST_WR_SETUP;
                     o_ram_data_oe <= 1'b1;
                     o_ram_wdata   <= i_wdata;
                  end else begin
                     r_state    <= ST_RD_SETUP;
                     o_ram_oe_n <= 1'b0;
                  end
               end
            end
            ST_RD_SETUP: begin
               r_state    <= ST_RD_LATCH;
               o_done     <= 1'b1;
               o_ram_ce_n <= 1'b0;
               o_ram_oe_n <= 1'b0;
               o_ram_addr <= w_addr_q_ext;
            end
            ST_WR_SETUP: begin
               r_state       <= ST_WR_PULSE;
               o_busy        <= 1'b1;
               o_ram_ce_n    <= 1'b0;
               o_ram_we_n    <= 1'b0;
               o_ram_data_oe <= 1'b1;
               o_ram_addr    <= w_addr_q_ext;
               o_ram_wdata   <= r_wdata_q;
            end
            ST_WR_PULSE: begin
               r_state       <= ST_WR_HOLD;
               o_done        <= 1'b1;
               o_ram_ce_n    <= 1'b0;
               o_ram_data_oe <= 1'b1;
               o_ram_addr    <= w_addr_q_ext;
               o_ram_wdata   <= r_wdata_q;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: launches SRAM accesses, stalls the front of the pipeline
// while one is in flight, and registers the selected write-back into MEM/WB.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = 18
) (
   input  logic                      clk_50MHz,
   input  logic                      rst,
   input  logic                      em_RAM_en,
   input  logic                      em_RAM_op,
   input  logic [WB_DATA_OP_BUS-1:0] em_DATA_op,
   input  logic [REG_OP_BUS-1:0]     em_REG_op,
   input  logic [DATA_BUS-1:0]       em_IH,
   input  logic [DATA_BUS-1:0]       em_PC,
   input  logic [DATA_BUS-1:0]       em_ALU_data,
   input  logic [DATA_BUS-1:0]       em_RAM_WB_data,
   input  logic [REG_ADDR_BUS-1:0]   em_WB_addr,
   output logic                      mem_stall,
   output logic [ADDR_W-1:0]         ram_addr,
   output logic [DATA_BUS-1:0]       ram_wdata,
   output logic                      ram_data_oe,
   input  logic [DATA_BUS-1:0]       ram_rdata,
   output logic                      ram_ce_n,
   output logic                      ram_oe_n,
   output logic                      ram_we_n,
   output logic [DATA_BUS-1:0]       mw_WB_data,
   output logic [REG_ADDR_BUS-1:0]   mw_WB_addr,
   output logic [REG_OP_BUS-1:0]     mw_REG_op
);

   logic                w_busy;
   logic                w_done;
   logic [DATA_BUS-1:0] w_wb_mux;

   sram_ctrl #(.ADDR_W(ADDR_W)) u_sram_ctrl (
      .i_clk         (clk_50MHz),
      .i_rst         (rst),
      .i_start       (em_RAM_en),
      .i_op          (em_RAM_op),
      .i_addr        (em_ALU_data),
      .i_wdata       (em_RAM_WB_data),
      .o_busy        (w_busy),
      .o_done        (w_done),
      .o_ram_addr    (ram_addr),
      .o_ram_wdata   (ram_wdata),
      .o_ram_data_oe (ram_data_oe),
      .o_ram_ce_n    (ram_ce_n),
      .o_ram_oe_n    (ram_oe_n),
      .o_ram_we_n    (ram_we_n)
   );

   assign w_wb_mux = wb_mux(em_DATA_op, em_ALU_data, em_PC, em_IH);

   // Neither busy nor done means IDLE, where a new request stalls immediately.
   assign mem_stall = w_busy || (!w_done && em_RAM_en);

   // MEM/WB register: retire on done, bubble while an access is pending, else pass through.
   always_ff @(posedge clk_50MHz) begin
      if (rst) begin
         mw_WB_data <= '0;
         mw_WB_addr <= '0;
         mw_REG_op  <= REG_OP_NONE;
      end else if (w_done) begin
         mw_WB_data <= (em_RAM_op == RAM_READ && em_DATA_op == WB_RAM) ? ram_rdata : w_wb_mux;
         mw_WB_addr <= em_WB_addr;
         mw_REG_op  <= em_REG_op;
      end else if (w_busy || em_RAM_en) begin
         mw_REG_op  <= REG_OP_NONE;
      end else begin
         mw_WB_data <= w_wb_mux;
         mw_WB_addr <= em_WB_addr;
         mw_REG_op  <= em_REG_op;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a driver issues instructions and pushes the
// expected MEM/WB result; a monitor pops whenever a real write-back appears.
module tb_mem_stage;

   logic        clk_50MHz = 1'b0;
   logic        rst;
   logic        em_RAM_en, em_RAM_op;
   logic [1:0]  em_DATA_op, em_REG_op;
   logic [15:0] em_IH, em_PC, em_ALU_data, em_RAM_WB_data;
   logic [3:0]  em_WB_addr;
   logic        mem_stall;
   logic [17:0] ram_addr;
   logic [15:0] ram_wdata, ram_rdata;
   logic        ram_data_oe, ram_ce_n, ram_oe_n, ram_we_n;
   logic [15:0] mw_WB_data;
   logic [3:0]  mw_WB_addr;
   logic [1:0]  mw_REG_op;

   always #10 clk_50MHz = ~clk_50MHz;

   mem_stage #(.ADDR_W(18)) dut (
      .clk_50MHz      (clk_50MHz),
      .rst            (rst),
      .em_RAM_en      (em_RAM_en),
      .em_RAM_op      (em_RAM_op),
      .em_DATA_op     (em_DATA_op),
      .em_REG_op      (em_REG_op),
      .em_IH          (em_IH),
      .em_PC          (em_PC),
      .em_ALU_data    (em_ALU_data),
      .em_RAM_WB_data (em_RAM_WB_data),
      .em_WB_addr     (em_WB_addr),
      .mem_stall      (mem_stall),
      .ram_addr       (ram_addr),
      .ram_wdata      (ram_wdata),
      .ram_data_oe    (ram_data_oe),
      .ram_rdata      (ram_rdata),
      .ram_ce_n       (ram_ce_n),
      .ram_oe_n       (ram_oe_n),
      .ram_we_n       (ram_we_n),
      .mw_WB_data     (mw_WB_data),
      .mw_WB_addr     (mw_WB_addr),
      .mw_REG_op      (mw_REG_op)
   );

   // SRAM model: combinational read, write committed on the rising edge of we_n.
   logic [15:0] sram [0:1023];
   assign ram_rdata = (!ram_ce_n && !ram_oe_n) ? sram[ram_addr[9:0]] : 16'h0000;
   always @(posedge ram_we_n)
      if (ram_ce_n === 1'b0 && ram_data_oe === 1'b1) sram[ram_addr[9:0]] = ram_wdata;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [15:0] d;
      logic [3:0]  a;
      logic [1:0]  r;
   } wb_t;
   wb_t exp_q[$];

   // Scoreboard monitor: every non-NONE write-back is one retired instruction.
   always @(negedge clk_50MHz) begin
      if (rst === 1'b0 && mw_REG_op != 2'd0) begin
         check("sb_expected_present", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            wb_t e;
            e = exp_q.pop_front();
            check("mw_WB_data", 32'(mw_WB_data), 32'(e.d));
            check("mw_WB_addr", 32'(mw_WB_addr), 32'(e.a));
            check("mw_REG_op",  32'(mw_REG_op),  32'(e.r));
         end
      end
   end

   // Strobe monitor: cumulative counters plus address/data stability errors.
   int          oe_low = 0, we_low = 0, doe_cyc = 0, strobe_err = 0;
   logic [17:0] exp_rd_addr = '0, exp_wr_addr = '0;
   logic [15:0] exp_wdata = '0;
   always @(negedge clk_50MHz) begin
      if (rst === 1'b0) begin
         if (ram_oe_n === 1'b0) begin
            oe_low++;
            if (ram_addr !== exp_rd_addr || ram_ce_n !== 1'b0) strobe_err++;
         end
         if (ram_we_n === 1'b0) begin
            we_low++;
            if (ram_data_oe !== 1'b1) strobe_err++;
         end
         if (ram_data_oe === 1'b1) begin
            doe_cyc++;
            if (ram_addr !== exp_wr_addr || ram_wdata !== exp_wdata || ram_ce_n !== 1'b0)
               strobe_err++;
         end
      end
   end

   task automatic issue(input logic en, input logic op, input logic [1:0] dop,
                        input logic [1:0] rop, input logic [15:0] alu, input logic [15:0] wd,
                        input logic [15:0] pc, input logic [15:0] ih, input logic [3:0] wba,
                        input logic [15:0] exp_d, output int edges, output int stalls);
      logic s;
      em_RAM_en = en; em_RAM_op = op; em_DATA_op = dop; em_REG_op = rop;
      em_ALU_data = alu; em_RAM_WB_data = wd; em_PC = pc; em_IH = ih; em_WB_addr = wba;
      if (rop != 2'd0) exp_q.push_back('{d: exp_d, a: wba, r: rop});
      edges  = 0;
      stalls = 0;
      do begin
         @(negedge clk_50MHz);
         s = mem_stall;
         if (s) stalls++;
         @(posedge clk_50MHz);
         edges++;
      end while (s && edges < 20);
      #1;
      check("instr_retired", 32'(s), 32'd0);
   endtask

   task automatic nop();
      int e, s;
      issue(1'b0, 1'b0, 2'd0, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 4'h0, 16'h0, e, s);
   endtask

   initial begin
      int e1, s1, e2, s2;
      int oe0, we0, doe0, err0;
      for (int i = 0; i < 1024; i++) sram[i] = 16'h0000;
      sram[10'h040] = 16'hBEEF;
      sram[10'h041] = 16'h1357;

      rst = 1'b1;
      em_RAM_en = 0; em_RAM_op = 0; em_DATA_op = 0; em_REG_op = 0;
      em_IH = 0; em_PC = 0; em_ALU_data = 0; em_RAM_WB_data = 0; em_WB_addr = 0;
      repeat (3) @(posedge clk_50MHz);
      #1;
      check("rst_ce_n",      32'(ram_ce_n),    32'd1);
      check("rst_oe_n",      32'(ram_oe_n),    32'd1);
      check("rst_we_n",      32'(ram_we_n),    32'd1);
      check("rst_data_oe",   32'(ram_data_oe), 32'd0);
      check("rst_ram_addr",  32'(ram_addr),    32'd0);
      check("rst_mw_REG_op", 32'(mw_REG_op),   32'd0);
      check("rst_mw_data",   32'(mw_WB_data),  32'd0);
      check("rst_stall",     32'(mem_stall),   32'd0);
      rst = 1'b0;

      // ALU pass-through
      issue(1'b0, 1'b0, 2'd0, 2'd1, 16'h1234, 16'h0, 16'h0, 16'h0, 4'd3, 16'h1234, e1, s1);
      check("alu_stalls", 32'(s1), 32'd0);
      check("alu_cycles", 32'(e1), 32'd1);
      nop();

      // RAM source without a memory access gives 0
      issue(1'b0, 1'b0, 2'd1, 2'd1, 16'h5555, 16'h0, 16'h0, 16'h0, 4'd4, 16'h0000, e1, s1);
      // PC then IH select
      issue(1'b0, 1'b0, 2'd2, 2'd2, 16'h1111, 16'h0, 16'h0008, 16'h8000, 4'd5, 16'h0008, e1, s1);
      issue(1'b0, 1'b0, 2'd3, 2'd3, 16'h1111, 16'h0, 16'h0008, 16'h8000, 4'd6, 16'h8000, e1, s1);
      nop();

      // Load
      exp_rd_addr = 18'h00040;
      oe0 = oe_low; err0 = strobe_err;
      issue(1'b1, 1'b0, 2'd1, 2'd1, 16'h0040, 16'h0, 16'h0, 16'h0, 4'd7, 16'hBEEF, e1, s1);
      check("load_stalls", 32'(s1), 32'd2);
      check("load_cycles", 32'(e1), 32'd3);
      check("load_oe_low", 32'(oe_low - oe0), 32'd2);
      check("load_addr",   32'(strobe_err - err0), 32'd0);
      nop();

      // Store
      exp_wr_addr = 18'h00100; exp_wdata = 16'hA5A5;
      we0 = we_low; doe0 = doe_cyc; err0 = strobe_err;
      issue(1'b1, 1'b1, 2'd0, 2'd0, 16'h0100, 16'hA5A5, 16'h0, 16'h0, 4'd0, 16'h0, e1, s1);
      check("store_stalls",  32'(s1), 32'd3);
      check("store_cycles",  32'(e1), 32'd4);
      check("store_we_low",  32'(we_low - we0), 32'd1);
      check("store_doe_cyc", 32'(doe_cyc - doe0), 32'd3);
      check("store_stable",  32'(strobe_err - err0), 32'd0);
      check("store_sram",    32'(sram[10'h100]), 32'h0000A5A5);
      nop();

      // Back-to-back load then store
      exp_rd_addr = 18'h00041; exp_wr_addr = 18'h00102; exp_wdata = 16'h2468;
      oe0 = oe_low; we0 = we_low; doe0 = doe_cyc; err0 = strobe_err;
      issue(1'b1, 1'b0, 2'd1, 2'd1, 16'h0041, 16'h0, 16'h0, 16'h0, 4'd2, 16'h1357, e1, s1);
      issue(1'b1, 1'b1, 2'd0, 2'd0, 16'h0102, 16'h2468, 16'h0, 16'h0, 4'd0, 16'h0, e2, s2);
      check("b2b_cycles",  32'(e1 + e2), 32'd7);
      check("b2b_stalls",  32'(s1 + s2), 32'd5);
      check("b2b_oe_low",  32'(oe_low - oe0), 32'd2);
      check("b2b_we_low",  32'(we_low - we0), 32'd1);
      check("b2b_doe_cyc", 32'(doe_cyc - doe0), 32'd3);
      check("b2b_stable",  32'(strobe_err - err0), 32'd0);
      check("b2b_sram",    32'(sram[10'h102]), 32'h00002468);
      nop();

      // Reset in the middle of the write pulse
      issue(1'b0, 1'b0, 2'd0, 2'd1, 16'h7777, 16'h0, 16'h0, 16'h0, 4'd9, 16'h7777, e1, s1);
      exp_wr_addr = 18'h00200; exp_wdata = 16'hFFFF;
      em_RAM_en = 1; em_RAM_op = 1; em_DATA_op = 0; em_REG_op = 0;
      em_ALU_data = 16'h0200; em_RAM_WB_data = 16'hFFFF; em_WB_addr = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_50MHz);
         if (ram_we_n === 1'b0) break;
      end
      check("reach_wr_pulse", 32'(ram_we_n), 32'd0);
      rst = 1'b1;
      @(posedge clk_50MHz);
      #1;
      check("rstw_we_n",      32'(ram_we_n),    32'd1);
      check("rstw_ce_n",      32'(ram_ce_n),    32'd1);
      check("rstw_oe_n",      32'(ram_oe_n),    32'd1);
      check("rstw_data_oe",   32'(ram_data_oe), 32'd0);
      check("rstw_ram_addr",  32'(ram_addr),    32'd0);
      check("rstw_mw_REG_op", 32'(mw_REG_op),   32'd0);
      check("rstw_mw_data",   32'(mw_WB_data),  32'd0);
      check("rstw_mw_addr",   32'(mw_WB_addr),  32'd0);
      check("rstw_stall_en1", 32'(mem_stall),   32'd1);
      em_RAM_en = 0; em_RAM_op = 0; em_ALU_data = 0; em_RAM_WB_data = 0;
      #1;
      check("rstw_stall_en0", 32'(mem_stall),   32'd0);
      @(posedge clk_50MHz);
      #1;
      rst = 1'b0;

      // Normal operation after reset
      issue(1'b0, 1'b0, 2'd0, 2'd1, 16'hABCD, 16'h0, 16'h0, 16'h0, 4'd1, 16'hABCD, e1, s1);
      nop();

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk_50MHz);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
